// File: rtl/envelope_shaper.sv
// -----------------------------------------------------------------------------
// envelope_shaper
//
// Amplitude-envelope stage between the sine generator and the two PWM DACs.
// Both half-wave magnitudes are scaled by an 8-bit gain that follows an
// attack / sustain / release profile, restarted on every note_start, so that
// pitch changes in the note sequencer do not produce audible clicks.
// The envelope advances on fs_tick; the scaled samples are re-registered on
// every clk cycle so the DACs always see flop outputs.
//
// Optional feature macro: ENVELOPE_RELEASE_EN
//   defined   : a note enters RELEASE once its remaining duration is short
//               enough for the gain to ramp down to 0 before it ends.
//   undefined : SUSTAIN holds gain 255 until the next note_start or reset.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   fs_tick    in   one-cycle pulse at the sample rate
//   note_start in   one-cycle pulse, a new note begins
//   duration   in   note length in fs ticks, sampled with note_start
//   pos_in     in   positive half-wave magnitude
//   neg_in     in   negative half-wave magnitude
//   pos_out    out  (pos_in * gain) >> 8, registered
//   neg_out    out  (neg_in * gain) >> 8, registered
//   gain       out  current envelope gain
//   busy       out  high whenever the envelope is not IDLE
// -----------------------------------------------------------------------------
module envelope_shaper #(
    parameter int WIDTH        = 9,
    parameter int DUR_BITS     = 13,
    parameter int ATTACK_STEP  = 16,
    parameter int RELEASE_STEP = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fs_tick,
    input  logic                note_start,
    input  logic [DUR_BITS-1:0] duration,
    input  logic [WIDTH-1:0]    pos_in,
    input  logic [WIDTH-1:0]    neg_in,
    output logic [WIDTH-1:0]    pos_out,
    output logic [WIDTH-1:0]    neg_out,
    output logic [7:0]          gain,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

`ifdef ENVELOPE_RELEASE_EN
    // Ticks needed to ramp from full scale down to 0.
    localparam int REL_TICKS = (255 + RELEASE_STEP - 1) / RELEASE_STEP;
`endif

    // Add computed 9 bits wide so the carry shows overflow past 255.
    function automatic logic [7:0] gain_add_sat(input logic [7:0] g);
        logic [8:0] sum;
        sum = {1'b0, g} + 9'(ATTACK_STEP);
        if (sum > 9'd255) begin
            return 8'd255;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Subtract computed 9 bits wide; bit 8 set means it went below 0.
    function automatic logic [7:0] gain_sub_sat(input logic [7:0] g);
        logic [8:0] diff;
        diff = {1'b0, g} - 9'(RELEASE_STEP);
        if (diff[8]) begin
            return 8'd0;
        end else begin
            return diff[7:0];
        end
    endfunction

    state_t                state_q, state_d;
    logic [7:0]            gain_q, gain_d;
    logic [DUR_BITS-1:0]   remaining_q, remaining_d;
    logic [DUR_BITS-1:0]   rem_dec;
    logic [WIDTH-1:0]      pos_out_q, pos_out_d;
    logic [WIDTH-1:0]      neg_out_q, neg_out_d;
    logic                  busy_q, busy_d;
    logic [WIDTH+7:0]      pos_prod;
    logic [WIDTH+7:0]      neg_prod;

    // Envelope next-state: note_start wins over a coincident fs_tick.
    always_comb begin
        state_d     = state_q;
        gain_d      = gain_q;
        remaining_d = remaining_q;
        rem_dec     = (remaining_q != {DUR_BITS{1'b0}}) ?
                      (remaining_q - {{(DUR_BITS-1){1'b0}}, 1'b1}) :
                      {DUR_BITS{1'b0}};

        if (note_start) begin
            state_d     = ST_ATTACK;
            gain_d      = 8'd0;
            remaining_d = duration;
        end else if (fs_tick) begin
            case (state_q)
                ST_IDLE: begin
                    gain_d = 8'd0;
                end
                ST_ATTACK: begin
                    remaining_d = rem_dec;
                    gain_d      = gain_add_sat(gain_q);
                    if (gain_d == 8'd255) begin
                        state_d = ST_SUSTAIN;
                    end else begin
                        state_d = ST_ATTACK;
                    end
`ifdef ENVELOPE_RELEASE_EN
                    // Release starts from the current gain, not from 255.
                    if (rem_dec <= DUR_BITS'(REL_TICKS)) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = state_d;
                    end
`endif
                end
                ST_SUSTAIN: begin
                    remaining_d = rem_dec;
                    gain_d      = 8'd255;
`ifdef ENVELOPE_RELEASE_EN
                    if (rem_dec <= DUR_BITS'(REL_TICKS)) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_SUSTAIN;
                    end
`else
                    state_d = ST_SUSTAIN;
`endif
                end
                ST_RELEASE: begin
                    remaining_d = rem_dec;
                    gain_d      = gain_sub_sat(gain_q);
                    if (gain_d == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    gain_d  = 8'd0;
                end
            endcase
        end else begin
            state_d     = state_q;
            gain_d      = gain_q;
            remaining_d = remaining_q;
        end
    end

    // Sample scaling with the gain currently held in the register.
    always_comb begin
        pos_prod  = (WIDTH+8)'(pos_in) * (WIDTH+8)'(gain_q);
        neg_prod  = (WIDTH+8)'(neg_in) * (WIDTH+8)'(gain_q);
        pos_out_d = WIDTH'(pos_prod >> 8);
        neg_out_d = WIDTH'(neg_prod >> 8);
        busy_d    = (state_d != ST_IDLE);
    end

    // State, gain, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gain_q      <= 8'd0;
            remaining_q <= {DUR_BITS{1'b0}};
            pos_out_q   <= {WIDTH{1'b0}};
            neg_out_q   <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            remaining_q <= remaining_d;
            pos_out_q   <= pos_out_d;
            neg_out_q   <= neg_out_d;
            busy_q      <= busy_d;
        end
    end

    assign pos_out = pos_out_q;
    assign neg_out = neg_out_q;
    assign gain    = gain_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_envelope_shaper.sv
// -----------------------------------------------------------------------------
// tb_envelope_shaper
//
// Directed bench for envelope_shaper at default parameters. Inputs change on
// the falling edge, outputs are read on the falling edge. Release-dependent
// scenarios follow the ENVELOPE_RELEASE_EN macro of the build.
// -----------------------------------------------------------------------------
module tb_envelope_shaper;

    logic        clk;
    logic        reset;
    logic        fs_tick;
    logic        note_start;
    logic [12:0] duration;
    logic [8:0]  pos_in;
    logic [8:0]  neg_in;
    logic [8:0]  pos_out;
    logic [8:0]  neg_out;
    logic [7:0]  gain;
    logic        busy;

    int checks;
    int errors;

    envelope_shaper dut (
        .clk        (clk),
        .reset      (reset),
        .fs_tick    (fs_tick),
        .note_start (note_start),
        .duration   (duration),
        .pos_in     (pos_in),
        .neg_in     (neg_in),
        .pos_out    (pos_out),
        .neg_out    (neg_out),
        .gain       (gain),
        .busy       (busy)
    );

    // 10 MHz system clock
    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    task automatic do_tick();
        @(negedge clk);
        fs_tick = 1'b1;
        @(negedge clk);
        fs_tick = 1'b0;
    endtask

    task automatic start_note(input logic [12:0] d);
        @(negedge clk);
        note_start = 1'b1;
        duration   = d;
        @(negedge clk);
        note_start = 1'b0;
        duration   = 13'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pos_in = 9'd300;
        neg_in = 9'd200;
        apply_reset();
        checks++;
        if (gain !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gain=%0d busy=%0d, want gain=0 busy=0", gain, busy);
        end
        checks++;
        if (pos_out !== 9'd0 || neg_out !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: pos=%0d neg=%0d, want 0 0", pos_out, neg_out);
        end
    endtask

    task automatic test_attack_ramp();
        int exp_g;
        start_note(13'd4000);
        checks++;
        if (gain !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL attack_start: gain=%0d busy=%0d, want 0 1", gain, busy);
        end
        for (int i = 1; i <= 16; i++) begin
            do_tick();
            exp_g = (i < 16) ? 16 * i : 255;
            checks++;
            if (gain !== 8'(exp_g)) begin
                errors++;
                $display("FAIL attack_tick%0d: gain=%0d, want %0d", i, gain, exp_g);
            end
        end
        // Sustain holds 255 on further ticks
        do_tick();
        do_tick();
        checks++;
        if (gain !== 8'd255 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sustain_hold: gain=%0d busy=%0d, want 255 1", gain, busy);
        end
        pos_in = 9'd400;
        neg_in = 9'd511;
        idle_cycle();
        checks++;
        if (pos_out !== 9'd398) begin
            errors++;
            $display("FAIL scale_pos_255: pos_out=%0d, want 398", pos_out);
        end
        checks++;
        if (neg_out !== 9'd509) begin
            errors++;
            $display("FAIL scale_neg_255: neg_out=%0d, want 509", neg_out);
        end
        pos_in = 9'd1;
        neg_in = 9'd256;
        idle_cycle();
        checks++;
        if (pos_out !== 9'd0 || neg_out !== 9'd255) begin
            errors++;
            $display("FAIL scale_small: pos=%0d neg=%0d, want 0 255", pos_out, neg_out);
        end
    endtask

    task automatic test_retrigger();
        // Currently sustaining: note_start and fs_tick in the same cycle
        @(negedge clk);
        note_start = 1'b1;
        fs_tick    = 1'b1;
        duration   = 13'd4000;
        @(negedge clk);
        note_start = 1'b0;
        fs_tick    = 1'b0;
        duration   = 13'd0;
        checks++;
        if (gain !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL retrig_restart: gain=%0d busy=%0d, want 0 1", gain, busy);
        end
        idle_cycle();
        checks++;
        if (gain !== 8'd0) begin
            errors++;
            $display("FAIL retrig_tick_ignored: gain=%0d, want 0", gain);
        end
        do_tick();
        checks++;
        if (gain !== 8'd16) begin
            errors++;
            $display("FAIL retrig_first_tick: gain=%0d, want 16", gain);
        end
    endtask

    task automatic test_reset_mid_note();
        apply_reset();
        start_note(13'd4000);
        for (int i = 1; i <= 8; i++) begin
            do_tick();
        end
        checks++;
        if (gain !== 8'd128) begin
            errors++;
            $display("FAIL mid_gain128: gain=%0d, want 128", gain);
        end
        pos_in = 9'd300;
        neg_in = 9'd7;
        idle_cycle();
        checks++;
        if (pos_out !== 9'd150 || neg_out !== 9'd3) begin
            errors++;
            $display("FAIL scale_128: pos=%0d neg=%0d, want 150 3", pos_out, neg_out);
        end
        // Reset with a coincident note_start that must be discarded
        @(negedge clk);
        reset      = 1'b1;
        note_start = 1'b1;
        duration   = 13'd50;
        @(negedge clk);
        reset      = 1'b0;
        note_start = 1'b0;
        duration   = 13'd0;
        checks++;
        if (gain !== 8'd0 || busy !== 1'b0 || pos_out !== 9'd0 || neg_out !== 9'd0) begin
            errors++;
            $display("FAIL reset_mid_note: gain=%0d busy=%0d pos=%0d neg=%0d, want all 0",
                     gain, busy, pos_out, neg_out);
        end
        do_tick();
        checks++;
        if (gain !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL note_in_reset_dropped: gain=%0d busy=%0d, want 0 0", gain, busy);
        end
    endtask

`ifdef ENVELOPE_RELEASE_EN
    task automatic test_release();
        int exp_g;
        apply_reset();
        start_note(13'd100);
        for (int i = 1; i <= 84; i++) begin
            do_tick();
        end
        checks++;
        if (gain !== 8'd255 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rel_entry_tick84: gain=%0d busy=%0d, want 255 1", gain, busy);
        end
        for (int t = 85; t <= 100; t++) begin
            do_tick();
            exp_g = 255 - 16 * (t - 84);
            if (exp_g < 0) exp_g = 0;
            checks++;
            if (gain !== 8'(exp_g) || busy !== (t < 100)) begin
                errors++;
                $display("FAIL rel_tick%0d: gain=%0d busy=%0d, want %0d %0d",
                         t, gain, busy, exp_g, (t < 100));
            end
        end
    endtask

    task automatic test_short_note();
        logic [12:0] durs [2];
        durs[0] = 13'd10;
        durs[1] = 13'd0;
        for (int k = 0; k < 2; k++) begin
            start_note(durs[k]);
            do_tick();
            checks++;
            if (gain !== 8'd16 || busy !== 1'b1) begin
                errors++;
                $display("FAIL short%0d_tick1: gain=%0d busy=%0d, want 16 1", durs[k], gain, busy);
            end
            do_tick();
            checks++;
            if (gain !== 8'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL short%0d_tick2: gain=%0d busy=%0d, want 0 0", durs[k], gain, busy);
            end
        end
    endtask
`else
    task automatic test_no_release();
        apply_reset();
        start_note(13'd20);
        for (int i = 1; i <= 16; i++) begin
            do_tick();
        end
        for (int i = 0; i < 100; i++) begin
            do_tick();
            checks++;
            if (gain !== 8'd255 || busy !== 1'b1) begin
                errors++;
                $display("FAIL norel_tick%0d: gain=%0d busy=%0d, want 255 1", i, gain, busy);
            end
        end
    endtask

    task automatic test_short_note();
        // Without release, a short or zero duration still attacks normally
        start_note(13'd0);
        do_tick();
        do_tick();
        checks++;
        if (gain !== 8'd32 || busy !== 1'b1) begin
            errors++;
            $display("FAIL short_norel: gain=%0d busy=%0d, want 32 1", gain, busy);
        end
    endtask
`endif

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        fs_tick    = 1'b0;
        note_start = 1'b0;
        duration   = 13'd0;
        pos_in     = 9'd0;
        neg_in     = 9'd0;

        test_reset();
        test_attack_ramp();
        test_retrigger();
        test_reset_mid_note();
`ifdef ENVELOPE_RELEASE_EN
        test_release();
`else
        test_no_release();
`endif
        test_short_note();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
